datamem_bank: RTL and testbench
===============================

# datamem_bank

Parametrised data memory for the single-cycle datapath, successor to the fixed 64 x 16 data memory. It adds width/depth parameters, byte-enabled writes, a registered read port with a valid strobe, out-of-range detection, and a sequenced clear engine that replaces the single-cycle array wipe. It sits between the datapath's load/store stage and the VGA-visible state, behind a valid/ready request port.

## Interface
- DATA_W, 16, word width in bits; multiple of 8
- ADDR_W, 12, request address width
- DEPTH, 64, number of words; DEPTH <= 2**ADDR_W
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous request to re-clear the whole array
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_write  in  1  1 = write, 0 = read
- addr  in  ADDR_W  word address
- wdata  in  DATA_W  write data
- byte_en  in  DATA_W/8  per-byte write enable, bit i covers wdata[8i+7:8i]
- rd_valid  out  1  one-cycle strobe: rd_data holds a read result
- rd_data  out  DATA_W  read result; holds last value between reads
- err  out  1  one-cycle strobe: accepted request had addr >= DEPTH
- init_busy  out  1  clear engine running

## Operation
- States: INIT (clearing), RUN (serving requests).
- Reset (async): state INIT, clear counter 0; req_ready 0, rd_valid 0, rd_data 0, err 0, init_busy 1.
- INIT: each rising edge writes 0 to word[counter], counter increments; after word DEPTH-1 is written, state -> RUN, init_busy -> 0.
- RUN: req_ready = !clr. Accept = req_valid && req_ready.
- Accepted write, addr < DEPTH: for each i with byte_en[i]=1, byte i of word[addr] <= wdata byte i; other bytes unchanged. byte_en = 0 is a legal no-op.
- Accepted read, addr < DEPTH: rd_data <= word[addr], rd_valid 1 next cycle.
- addr >= DEPTH: write is dropped, memory unchanged; read returns rd_data 0 with rd_valid 1; err 1 for one cycle for either type.
- clr high in RUN: no request accepted that cycle; state -> INIT, counter 0. clr high in INIT: counter restarts at 0.
- Address compare uses full ADDR_W bits; no truncation or aliasing.

## Timing
- First edge with rst low clears word 0; req_ready rises after edge DEPTH (DEPTH cycles of init_busy after rst release).
- Read latency 1: request accepted at edge N -> rd_valid/rd_data valid after edge N, sampled at edge N+1.
- Back-to-back one request per cycle, no bubbles.
- Write at edge N then read same addr at edge N+1 returns new data (no forwarding hazard: write commits at N).
- rd_valid and err are single-cycle strobes, low whenever no request was accepted the previous cycle.
- rst asserted mid-INIT or mid-RUN: immediate return to reset values; in-flight read result discarded; clear restarts from word 0.
- Array contents are not reset asynchronously; zeroing is only via INIT.

## Structure
- Package datamem_pkg: state enum {INIT, RUN}; function deriving byte count DATA_W/8; clog2-based counter width for DEPTH.
- Sub-module datamem_array: storage only, one write port with byte enables, one synchronous read port; the top holds FSM, counter, range check, strobes.

## Test plan
- Reset release -> init_busy 1 for exactly 64 cycles, req_ready 0 then 1; read of addr 0, 37, 63 each returns 0x0000 with rd_valid one cycle later.
- Write 0xBEEF to addr 5, byte_en 2'b11, then read addr 5 next cycle -> rd_data 0xBEEF, rd_valid 1, err 0.
- Write 0x12AB to addr 5 with byte_en 2'b01 over 0xBEEF -> read returns 0xBEAB; byte_en 2'b00 write -> still 0xBEAB.
- Write 0x5555 to addr 64, then read addr 4095 -> err strobes on both, read gives rd_data 0 with rd_valid 1; addr 0 still 0x0000 (no aliasing).
- clr pulsed in RUN with req_valid high -> req_ready 0 that cycle, init_busy 64 cycles, previously written addr 5 reads 0x0000 afterwards.
- rst asserted at init counter 30, released -> full 64-cycle clear restarts; rst during a pending read -> rd_valid stays 0.

Source files
------------

// File: rtl/datamem_pkg.sv
// Shared types and sizing helpers for the parametrised data memory bank.
package datamem_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int byte_count(input int data_w);
        return data_w / 8;
    endfunction

    // Counter never narrower than one bit, even for a single-word array.
    function automatic int cnt_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/datamem_array.sv
// Word storage with one byte-enabled write port and one registered read port.
module datamem_array
    import datamem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int AW     = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W/8-1:0]      wbe,
    input  logic                     re,
    input  logic [AW-1:0]            raddr,
    input  logic                     rzero,
    output logic [DATA_W-1:0]        rdata
);

    localparam int NB = byte_count(DATA_W);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Byte-lane writes; contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    mem_r[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read register only moves on a read; out-of-range reads load zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if (re) begin
            rdata_r <= rzero ? {DATA_W{1'b0}} : mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/datamem_bank.sv
// Data memory bank: clear engine FSM, request port, range check and read/err strobes.
module datamem_bank
    import datamem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W/8-1:0]      byte_en,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     err,
    output logic                     init_busy
);

    localparam int NB = byte_count(DATA_W);
    localparam int CW = cnt_width(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [CW-1:0]   LAST    = CW'(DEPTH - 1);

    state_t              state_r, state_s;
    logic [CW-1:0]       cnt_r, cnt_s;
    logic                rd_valid_r, err_r;
    logic                in_range_s, ready_s, accept_s;
    logic                we_s, re_s;
    logic [CW-1:0]       waddr_s;
    logic [DATA_W-1:0]   wdata_s;
    logic [NB-1:0]       wbe_s;

    // Full-width compare so high address bits can never alias into the array.
    assign in_range_s = ({1'b0, addr} < DEPTH_X);
    assign ready_s    = (state_r == RUN) && !clr;
    assign accept_s   = req_valid && ready_s;

    // State, clear counter and response strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= INIT;
            cnt_r      <= {CW{1'b0}};
            rd_valid_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            rd_valid_r <= accept_s && !req_write;
            err_r      <= accept_s && !in_range_s;
        end
    end

    // Next-state logic and array port steering.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        we_s    = 1'b0;
        re_s    = 1'b0;
        waddr_s = cnt_r;
        wdata_s = {DATA_W{1'b0}};
        wbe_s   = {NB{1'b0}};
        case (state_r)
            INIT: begin
                if (clr) begin
                    cnt_s = {CW{1'b0}};
                end else begin
                    we_s  = 1'b1;
                    wbe_s = {NB{1'b1}};
                    if (cnt_r == LAST) begin
                        state_s = RUN;
                        cnt_s   = {CW{1'b0}};
                    end else begin
                        cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
            end
            RUN: begin
                if (clr) begin
                    state_s = INIT;
                    cnt_s   = {CW{1'b0}};
                end else if (accept_s) begin
                    waddr_s = addr[CW-1:0];
                    if (req_write) begin
                        we_s    = in_range_s;
                        wdata_s = wdata;
                        wbe_s   = byte_en;
                    end else begin
                        re_s = 1'b1;
                    end
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                state_s = INIT;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    datamem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (CW)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (wdata_s),
        .wbe   (wbe_s),
        .re    (re_s),
        .raddr (addr[CW-1:0]),
        .rzero (!in_range_s),
        .rdata (rd_data)
    );

    assign req_ready = ready_s;
    assign rd_valid  = rd_valid_r;
    assign err       = err_r;
    assign init_busy = (state_r == INIT);

endmodule

// File: tb/tb_datamem_bank.sv
// Directed bench for datamem_bank with hand-computed expected values.
module tb_datamem_bank;

    logic        clk = 1'b0;
    logic        rst, clr, req_valid, req_ready, req_write;
    logic [11:0] addr;
    logic [15:0] wdata, rd_data;
    logic [1:0]  byte_en;
    logic        rd_valid, err, init_busy;

    int n_checks = 0;
    int n_errors = 0;

    datamem_bank #(.DATA_W(16), .ADDR_W(12), .DEPTH(64)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .addr(addr), .wdata(wdata), .byte_en(byte_en),
        .rd_valid(rd_valid), .rd_data(rd_data), .err(err), .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single edge; leaves it asserted for back-to-back use.
    task automatic req(input logic w, input logic [11:0] a, input logic [15:0] d, input logic [1:0] be);
        req_valid = 1'b1;
        req_write = w;
        addr      = a;
        wdata     = d;
        byte_en   = be;
        tick();
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_write = 1'b0;
        tick();
    endtask

    task automatic read_chk(input string tag, input logic [11:0] a, input logic [15:0] exp_d, input logic exp_e);
        req(1'b0, a, 16'h0000, 2'b00);
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check({tag, "_data"}, 32'(rd_data), 32'(exp_d));
        check({tag, "_err"}, 32'(err), 32'(exp_e));
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        while (init_busy && n < 200) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'd64);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        addr = 12'd0; wdata = 16'h0000; byte_en = 2'b00;
        tick();
        tick();
        check("rst_busy", 32'(init_busy), 32'd1);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        rst = 1'b0;
        req_valid = 1'b1;
        check("init_ready_low", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        wait_init("init_len");
        check("run_ready", 32'(req_ready), 32'd1);

        read_chk("rd0", 12'd0, 16'h0000, 1'b0);
        read_chk("rd37", 12'd37, 16'h0000, 1'b0);
        read_chk("rd63", 12'd63, 16'h0000, 1'b0);
        idle();
        check("rd_valid_strobe", 32'(rd_valid), 32'd0);

        // Write then read back-to-back, no bubble.
        req(1'b1, 12'd5, 16'hBEEF, 2'b11);
        check("wr_no_valid", 32'(rd_valid), 32'd0);
        check("wr_no_err", 32'(err), 32'd0);
        read_chk("rd5_full", 12'd5, 16'hBEEF, 1'b0);
        req(1'b1, 12'd5, 16'h12AB, 2'b01);
        read_chk("rd5_lo", 12'd5, 16'hBEAB, 1'b0);
        req(1'b1, 12'd5, 16'h7777, 2'b00);
        read_chk("rd5_none", 12'd5, 16'hBEAB, 1'b0);
        idle();
        check("hold_data", 32'(rd_data), 32'h0000BEAB);
        check("hold_valid", 32'(rd_valid), 32'd0);

        // Out-of-range requests.
        req(1'b1, 12'd64, 16'h5555, 2'b11);
        check("oor_wr_err", 32'(err), 32'd1);
        check("oor_wr_valid", 32'(rd_valid), 32'd0);
        read_chk("oor_rd", 12'd4095, 16'h0000, 1'b1);
        idle();
        check("err_strobe", 32'(err), 32'd0);
        read_chk("alias0", 12'd0, 16'h0000, 1'b0);
        read_chk("rd5_keep", 12'd5, 16'hBEAB, 1'b0);

        // Clear request in RUN blocks the request and restarts the wipe.
        req_valid = 1'b1; req_write = 1'b0; addr = 12'd5; clr = 1'b1;
        #1;
        check("clr_ready", 32'(req_ready), 32'd0);
        tick();
        clr = 1'b0; req_valid = 1'b0;
        check("clr_no_valid", 32'(rd_valid), 32'd0);
        check("clr_busy", 32'(init_busy), 32'd1);
        wait_init("clr_init_len");
        read_chk("rd5_cleared", 12'd5, 16'h0000, 1'b0);
        idle();

        // Reset mid-clear at counter 30.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (30) tick();
        check("mid_busy", 32'(init_busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_init("rst_init_len");

        // Reset while a read is being presented: no result may appear.
        req_valid = 1'b1; req_write = 1'b0; addr = 12'd37;
        rst = 1'b1;
        tick();
        check("rst_rd_drop", 32'(rd_valid), 32'd0);
        check("rst_rd_busy", 32'(init_busy), 32'd1);
        req_valid = 1'b0;
        rst = 1'b0;
        wait_init("rst2_init_len");
        read_chk("rd37_after", 12'd37, 16'h0000, 1'b0);
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
